// File: rtl/ysyx_24090012_ifu_pkg.sv
// Shared types and constants for the ysyx_24090012 instruction fetch unit.
package ysyx_24090012_ifu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned RESP_W = 2;

  localparam logic [RESP_W-1:0] RESP_OKAY    = 2'b00;
  localparam logic [XLEN-1:0]   NOP_INST     = 32'h0000_0013;
  localparam logic [XLEN-1:0]   RESET_PC_DEF = 32'h8000_0000;

  typedef enum logic [2:0] {
    S_BOOT = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_OUT  = 3'd3,
    S_WAIT = 3'd4
  } ifu_state_t;

  // Payload handed to the decode stage.
  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic            err;
  } fetch_t;

  function automatic logic pc_aligned(input logic [XLEN-1:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/ysyx_24090012_ifu.sv
// Instruction fetch unit: one AXI4-Lite read per instruction, inst/pc handed to IDU,
// then waits for the next pc from write-back (single outstanding fetch).
module ysyx_24090012_ifu
  import ysyx_24090012_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] ERR_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] ifu_araddr,
  output logic        ifu_arvalid,
  input  logic        ifu_arready,
  input  logic [31:0] ifu_rdata,
  input  logic [1:0]  ifu_rresp,
  input  logic        ifu_rvalid,
  output logic        ifu_rready,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic        fetch_err,
  input  logic [31:0] npc,
  input  logic        npc_valid,
  output logic        npc_ready,
  output logic [31:0] perf_fetch_cnt
);

  ifu_state_t      state_q, state_d;
  fetch_t          fetch_q, fetch_d;
  logic [XLEN-1:0] perf_cnt_q, perf_cnt_d;
  logic            arvalid_q, arvalid_d;
  logic            rready_q, rready_d;
  logic            inst_valid_q, inst_valid_d;
  logic            npc_ready_q, npc_ready_d;

  // Next-state, datapath updates and state-decoded handshake outputs.
  always_comb begin
    state_d    = state_q;
    fetch_d    = fetch_q;
    perf_cnt_d = perf_cnt_q;
    unique case (state_q)
      S_BOOT: state_d = S_AR;
      S_AR: begin
        if (ifu_arready) state_d = S_R;
      end
      S_R: begin
        if (ifu_rvalid) begin
          state_d = S_OUT;
          if (ifu_rresp == RESP_OKAY) begin
            fetch_d.inst = ifu_rdata;
            fetch_d.err  = 1'b0;
          end else begin
            fetch_d.inst = ERR_INST;
            fetch_d.err  = 1'b1;
          end
        end
      end
      S_OUT: begin
        if (inst_ready) begin
          state_d    = S_WAIT;
          perf_cnt_d = perf_cnt_q + XLEN'(1);
        end
      end
      S_WAIT: begin
        if (npc_valid) begin
          fetch_d.pc = npc;
          if (pc_aligned(npc)) begin
            state_d = S_AR;
          end else begin
            // Misaligned target never reaches the bus; report it as a faulting fetch.
            fetch_d.inst = ERR_INST;
            fetch_d.err  = 1'b1;
            state_d      = S_OUT;
          end
        end
      end
      default: state_d = S_BOOT;
    endcase
    arvalid_d    = (state_d == S_AR);
    rready_d     = (state_d == S_R);
    inst_valid_d = (state_d == S_OUT);
    npc_ready_d  = (state_d == S_WAIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_BOOT;
      fetch_q      <= '{inst: ERR_INST, pc: RESET_PC, err: 1'b0};
      perf_cnt_q   <= '0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      inst_valid_q <= 1'b0;
      npc_ready_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_q      <= fetch_d;
      perf_cnt_q   <= perf_cnt_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      inst_valid_q <= inst_valid_d;
      npc_ready_q  <= npc_ready_d;
    end
  end

  assign ifu_araddr     = fetch_q.pc;
  assign ifu_arvalid    = arvalid_q;
  assign ifu_rready     = rready_q;
  assign inst           = fetch_q.inst;
  assign pc             = fetch_q.pc;
  assign fetch_err      = fetch_q.err;
  assign inst_valid     = inst_valid_q;
  assign npc_ready      = npc_ready_q;
  assign perf_fetch_cnt = perf_cnt_q;

  // Read data is only meaningful while a read is outstanding.
  a_rvalid_in_r : assert property (@(posedge clk) disable iff (!rst_n)
    ifu_rvalid |-> (state_q == S_R));

endmodule

// File: tb/tb_ysyx_24090012_ifu.sv
// Directed bench for ysyx_24090012_ifu with a small AXI4-Lite read slave model.
module tb_ysyx_24090012_ifu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ifu_araddr;
  logic        ifu_arvalid;
  logic        ifu_arready;
  logic [31:0] ifu_rdata;
  logic [1:0]  ifu_rresp;
  logic        ifu_rvalid;
  logic        ifu_rready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        fetch_err;
  logic [31:0] npc;
  logic        npc_valid;
  logic        npc_ready;
  logic [31:0] perf_fetch_cnt;

  logic        arready_en;
  logic [1:0]  resp_cfg;
  int          ar_hs;
  int          n_chk = 0;
  int          n_bad = 0;
  int          hs_snap;

  always #5 clk = ~clk;

  ysyx_24090012_ifu dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
    .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid),
    .ifu_rready(ifu_rready), .inst(inst), .pc(pc), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .fetch_err(fetch_err), .npc(npc), .npc_valid(npc_valid),
    .npc_ready(npc_ready), .perf_fetch_cnt(perf_fetch_cnt)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h8000_0000) ? 32'h0050_0093 : {a[19:0], 12'h113};
  endfunction

  assign ifu_arready = arready_en;

  // Slave: data returned the cycle after the address handshake.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifu_rvalid <= 1'b0;
      ifu_rdata  <= '0;
      ifu_rresp  <= '0;
      ar_hs      <= 0;
    end else begin
      if (ifu_rvalid && ifu_rready) ifu_rvalid <= 1'b0;
      if (ifu_arvalid && ifu_arready) begin
        ifu_rvalid <= 1'b1;
        ifu_rdata  <= mem_word(ifu_araddr);
        ifu_rresp  <= resp_cfg;
        ar_hs      <= ar_hs + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_arvalid"}, 32'(ifu_arvalid), 32'd0);
    chk({tag, "_rready"},  32'(ifu_rready),  32'd0);
    chk({tag, "_ivalid"},  32'(inst_valid),  32'd0);
    chk({tag, "_npcrdy"},  32'(npc_ready),   32'd0);
    chk({tag, "_pc"},      pc,               32'h8000_0000);
    chk({tag, "_inst"},    inst,             32'h0000_0013);
    chk({tag, "_err"},     32'(fetch_err),   32'd0);
  endtask

  // From S_OUT: complete inst handshake, supply npc, end with DUT in the state after npc accept.
  task automatic next_pc(input logic [31:0] target);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    npc        = target;
    npc_valid  = 1'b1;
    tick();
    npc_valid  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; arready_en = 1'b1; resp_cfg = 2'b00;
    inst_ready = 1'b0; npc = '0; npc_valid = 1'b0;
    #12;
    chk_reset_outs("rst");
    chk("rst_perf", perf_fetch_cnt, 32'd0);

    // Boot, zero-wait fetch of 0x8000_0000.
    @(posedge clk); #1 rst_n = 1'b1;
    chk("boot_noar", 32'(ifu_arvalid), 32'd0);
    tick();
    chk("boot_arvalid", 32'(ifu_arvalid), 32'd1);
    chk("boot_araddr", ifu_araddr, 32'h8000_0000);
    tick();
    chk("boot_rready", 32'(ifu_rready), 32'd1);
    chk("boot_arlow", 32'(ifu_arvalid), 32'd0);
    tick();
    chk("boot_ivalid", 32'(inst_valid), 32'd1);
    chk("boot_inst", inst, 32'h0050_0093);
    chk("boot_pc", pc, 32'h8000_0000);
    chk("boot_err", 32'(fetch_err), 32'd0);
    chk("boot_arhs", 32'(ar_hs), 32'd1);

    // inst_ready held low for 5 cycles.
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_ivalid", 32'(inst_valid), 32'd1);
      chk("bp_inst", inst, 32'h0050_0093);
      chk("bp_perf", perf_fetch_cnt, 32'd0);
    end

    // Next fetch with arready low for 3 cycles.
    arready_en = 1'b0;
    next_pc(32'h8000_0004);
    chk("hs_perf", perf_fetch_cnt, 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("arst_arvalid", 32'(ifu_arvalid), 32'd1);
      chk("arst_araddr", ifu_araddr, 32'h8000_0004);
      tick();
    end
    chk("arst_arvalid4", 32'(ifu_arvalid), 32'd1);
    chk("arst_araddr4", ifu_araddr, 32'h8000_0004);
    arready_en = 1'b1;
    tick();
    tick();
    chk("arst_arhs", 32'(ar_hs), 32'd2);
    chk("arst_inst", inst, 32'h0000_4113);
    chk("arst_ivalid", 32'(inst_valid), 32'd1);

    // inst_ready and npc_valid together in S_OUT: npc waits a cycle.
    inst_ready = 1'b1; npc = 32'h8000_0008; npc_valid = 1'b1; resp_cfg = 2'b10;
    tick();
    inst_ready = 1'b0;
    chk("both_npcrdy", 32'(npc_ready), 32'd1);
    chk("both_pc", pc, 32'h8000_0004);
    chk("both_perf", perf_fetch_cnt, 32'd2);
    tick();
    npc_valid = 1'b0;
    chk("both_arvalid", 32'(ifu_arvalid), 32'd1);
    chk("both_araddr", ifu_araddr, 32'h8000_0008);
    tick(); tick();
    chk("flt_inst", inst, 32'h0000_0013);
    chk("flt_err", 32'(fetch_err), 32'd1);
    chk("flt_pc", pc, 32'h8000_0008);

    // Clean fetch afterwards clears the fault.
    resp_cfg = 2'b00;
    next_pc(32'h8000_000C);
    tick(); tick();
    chk("clr_err", 32'(fetch_err), 32'd0);
    chk("clr_inst", inst, 32'h0000_C113);

    // Misaligned npc: no bus access.
    hs_snap = ar_hs;
    next_pc(32'h8000_0006);
    chk("mis_ivalid", 32'(inst_valid), 32'd1);
    chk("mis_arvalid", 32'(ifu_arvalid), 32'd0);
    chk("mis_err", 32'(fetch_err), 32'd1);
    chk("mis_pc", pc, 32'h8000_0006);
    chk("mis_inst", inst, 32'h0000_0013);
    tick();
    chk("mis_arhs", 32'(ar_hs), 32'(hs_snap));
    chk("mis_perf", perf_fetch_cnt, 32'd4);

    // Counter wrap from a preloaded all-ones value.
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    force dut.perf_cnt_q = 32'hFFFF_FFFF;
    tick();
    release dut.perf_cnt_q;
    npc = 32'h8000_0010; npc_valid = 1'b1;
    tick();
    npc_valid = 1'b0;
    tick(); tick();
    chk("wrap_pre", perf_fetch_cnt, 32'hFFFF_FFFF);
    chk("wrap_inst", inst, 32'h0001_0113);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk("wrap_zero", perf_fetch_cnt, 32'd0);

    // Reset asserted while waiting for read data.
    npc = 32'h8000_0014; npc_valid = 1'b1;
    tick();
    npc_valid = 1'b0;
    tick();
    chk("rsr_rready", 32'(ifu_rready), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outs("rsr");
    chk("rsr_perf", perf_fetch_cnt, 32'd0);
    #1 rst_n = 1'b1;
    tick();
    chk("rsr_arvalid", 32'(ifu_arvalid), 32'd1);
    chk("rsr_araddr", ifu_araddr, 32'h8000_0000);
    tick(); tick();
    chk("rsr_inst", inst, 32'h0050_0093);
    chk("rsr_ivalid", 32'(inst_valid), 32'd1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
